// File: rtl/channel_arbiter_pkg.sv
// Shared types and helpers for the round-robin channel arbiter.
package channel_arbiter_pkg;
  localparam int DEF_NUM_CH   = 5;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_IDX_W    = 3;

  typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_e;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/channel_arbiter_if.sv
// Channel-side request/release and arbiter-side grant bundle.
interface channel_arbiter_if #(
  parameter int NUM_CH = 5,
  parameter int IDX_W  = 3
);
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] grant;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic              timeout;

  modport master (output req, done, input grant, grant_valid, grant_idx, timeout);
  modport slave  (input req, done, output grant, grant_valid, grant_idx, timeout);
endinterface

// File: rtl/channel_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_CH = 5,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  winner_o
);
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int s;
      s = int'(ptr_i) + i;
      if (s >= NUM_CH) s = s - NUM_CH;
      if (!found_o && req_i[s]) begin
        found_o  = 1'b1;
        winner_o = IDX_W'(s);
      end
    end
  end
endmodule

// File: rtl/channel_arbiter.sv
// Round-robin arbiter: one grant at a time, bounded tenure, one idle cycle between grants.
module channel_arbiter
  import channel_arbiter_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDX_W    = DEF_IDX_W
) (
  input logic              clock_i,
  input logic              reset_n_i,
  channel_arbiter_if.slave bus_io
);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_SAT = 8'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              gv_q, gv_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tout_q, tout_d;
  logic [7:0]        hold_q, hold_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic              found;
  logic [IDX_W-1:0]  winner;
  logic              vol_rel, at_lim;

  rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req_i    (bus_io.req),
    .ptr_i    (ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  assign vol_rel = !bus_io.req[idx_q] || bus_io.done[idx_q];
  assign at_lim  = (hold_q == HOLD_LIM);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gv_d    = gv_q;
    idx_d   = idx_q;
    tout_d  = 1'b0;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      // Leaving GAP decides the next winner on the same edge, keeping a single zero cycle.
      IDLE, GAP: begin
        state_d = IDLE;
        if (found) begin
          state_d        = OWN;
          grant_d        = '0;
          grant_d[winner] = 1'b1;
          gv_d           = 1'b1;
          idx_d          = winner;
          hold_d         = '0;
        end
      end
      OWN: begin
        if (vol_rel || at_lim) begin
          state_d = GAP;
          grant_d = '0;
          gv_d    = 1'b0;
          idx_d   = '0;
          tout_d  = at_lim && !vol_rel;
          ptr_d   = IDX_W'(next_idx(int'(idx_q), NUM_CH));
        end else begin
          hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      idx_q   <= '0;
      tout_q  <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      idx_q   <= idx_d;
      tout_q  <= tout_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus_io.grant       = grant_q;
  assign bus_io.grant_valid = gv_q;
  assign bus_io.grant_idx   = idx_q;
  assign bus_io.timeout     = tout_q;
endmodule
